sc_sync_ctrl: RTL and testbench
===============================

Name: sc_sync_ctrl

Overview:
- Detection sequencer for the Schmidl & Cox synchronizer.
- Consumes the per-sample normalized timing metric and the correlation phase. Decides when a plateau qualifies as a packet start.
- Emits a one-beat trigger together with a plateau-averaged CFO phase to drive the phase accumulator and the framer.
- Detection thresholds, plateau length and holdoff are runtime-configurable over the settings bus.

Parameters:
- BASE, 0, settings bus base address; the block occupies BASE+0..BASE+3.
- MAX_LEN_LOG2, 8, maximum log2 plateau length; the phase accumulator is 16+MAX_LEN_LOG2 bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous clear of FSM, counters and pipeline; settings are kept
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  32  [31:16] unsigned metric, [15:0] signed phase
- i_tlast  in  1  input packet end
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  32  [15:0] held CFO phase, [16] trigger, [31:17] zero
- o_tlast  out  1  registered copy of i_tlast
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- locked  out  1  high in the LOCKED state
- trig_count  out  16  number of triggers since reset/clear, wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs are 0. FSM=IDLE. Registers: thresh=0xFFFF, len_log2=4, holdoff=0, ctrl=0.
- Settings registers:
  - BASE+0 thresh[15:0]
  - BASE+1 len_log2[3:0], clamped to MAX_LEN_LOG2
  - BASE+2 holdoff[15:0]
  - BASE+3 ctrl: bit0 enable, bit1 one_shot
  - Writes take effect on the next accepted beat.
- Handshake:
  - One-stage output register; latency is exactly 1 accepted beat.
  - i_tready = o_tready | ~o_tvalid.
  - A beat is accepted when i_tvalid & i_tready. The FSM advances only on accepted beats.
  - While stalled, o_tdata/o_tlast are stable.
  - Every input beat produces exactly one output beat. No drops, no insertions.
- Qualification: qual = metric >= thresh (unsigned). PLEN = 2^len_log2.
- FSM (evaluated per accepted beat):
  - IDLE: trigger=0. If enable=1 -> SEARCH.
  - SEARCH: if qual -> PLATEAU with cnt=1, acc=sign-extended phase. If PLEN=1, the trigger fires on this beat instead (see the PLATEAU firing rule).
  - PLATEAU:
    - If qual: cnt+1, acc+phase.
    - When cnt reaches PLEN: output trigger=1 on this beat; held phase = acc >>> len_log2 (arithmetic); trig_count+1.
    - Next state: LOCKED if one_shot, else HOLDOFF (or SEARCH if holdoff=0).
    - If ~qual before reaching PLEN: -> SEARCH; cnt and acc cleared.
  - HOLDOFF: ignore qual and count beats. After holdoff beats -> SEARCH.
  - LOCKED: locked=1, no further triggers. Exit only on clear or enable=0.
  - From any state, enable=0 on an accepted beat -> IDLE. The held phase is retained.
- Held phase: updates only on a trigger beat. It is output on every beat so downstream always sees the last estimate.
- Output tdata: trigger is asserted on exactly one output beat per detection. It is aligned with the input beat that completed the plateau.
- Accumulator: 16+MAX_LEN_LOG2 bits, signed; cannot overflow because len_log2 <= MAX_LEN_LOG2.
- Clear: FSM -> IDLE (-> SEARCH on the next beat if enabled). cnt, acc, trig_count, locked, held phase and o_tvalid are cleared. Settings are retained.
- Reset mid-operation: asynchronous return to the reset values above.
- Simultaneous trigger and settings write: the trigger uses the old settings; the new values apply from the next beat.

Optional Feature:
- Macro SC_SYNC_TLAST_RESYNC_EN.
- When defined: an accepted beat with i_tlast=1 forces the next state to SEARCH from PLATEAU or HOLDOFF, clearing cnt/acc/holdoff. A trigger completing on that same beat is still emitted. LOCKED and IDLE are unaffected.
- When undefined: i_tlast is only passed through to o_tlast and never affects the FSM.

Test Plan:
- Reset, enable=1, thresh=1000, len_log2=2, holdoff=0. Feed 8 beats metric=2000, phase=100 -> trigger=1 on output beats 4 and 8 only, held phase=100, trig_count=2.
- Phases 100,200,300,400 over a qualifying plateau with len_log2=2 -> held phase=250 on trigger beat 4. Negative set -40,-40,-40,-40 -> 0xFFD8.
- Plateau broken: metric 2000,2000,500,2000,2000,2000,2000 with len_log2=2 -> single trigger on beat 7.
- holdoff=5, constant qualifying input -> triggers on beats 4 and 13. one_shot=1 -> single trigger at beat 4, locked=1 until clear pulse.
- Random o_tready (50%) and i_tvalid (50%) with the same stimulus -> output beat sequence identical to the full-throughput run; stalled outputs stable.
- With SC_SYNC_TLAST_RESYNC_EN: tlast on beat 2 of a 4-beat plateau -> no trigger until 4 fresh qualifying beats; without the macro -> trigger on beat 4.

Source files
------------

// File: rtl/sc_sync_ctrl.sv
// Schmidl & Cox detection sequencer: qualifies metric plateaus, emits a one-beat trigger with plateau-averaged CFO phase.
// Optional: define SC_SYNC_TLAST_RESYNC_EN to let i_tlast force PLATEAU/HOLDOFF back to SEARCH.
module sc_sync_ctrl #(
    parameter int unsigned BASE         = 0,
    parameter int unsigned MAX_LEN_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        locked,
    output logic [15:0] trig_count
);

    localparam int unsigned AW = 16 + MAX_LEN_LOG2;
    localparam int unsigned CW = MAX_LEN_LOG2 + 1;
    localparam logic [7:0] ADDR_THRESH  = 8'(BASE);
    localparam logic [7:0] ADDR_LEN     = 8'(BASE + 1);
    localparam logic [7:0] ADDR_HOLDOFF = 8'(BASE + 2);
    localparam logic [7:0] ADDR_CTRL    = 8'(BASE + 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_PLATEAU,
        S_HOLDOFF,
        S_LOCKED
    } state_t;

    logic [15:0] thresh;
    logic [3:0]  len_log2;
    logic [15:0] holdoff;
    logic        enable;
    logic        one_shot;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n, cnt_inc, plen;
    logic signed [AW-1:0]  acc, acc_n, acc_sum, phase_ext, fire_acc, held_shift;
    logic [15:0]           hcnt, hcnt_n;
    logic [16:0]           hcnt_inc;
    logic [15:0]           held, held_n;
    logic                  fire, accept, qual;
    logic                  unused_ok;

    assign unused_ok = ^{set_data[31:16], held_shift[AW-1:16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh   <= 16'hFFFF;
            len_log2 <= 4'd4;
            holdoff  <= '0;
            enable   <= 1'b0;
            one_shot <= 1'b0;
        end else if (set_stb) begin
            case (set_addr)
                ADDR_THRESH:  thresh <= set_data[15:0];
                ADDR_LEN:     len_log2 <= ({28'd0, set_data[3:0]} > MAX_LEN_LOG2) ?
                                          4'(MAX_LEN_LOG2) : set_data[3:0];
                ADDR_HOLDOFF: holdoff <= set_data[15:0];
                ADDR_CTRL: begin
                    enable   <= set_data[0];
                    one_shot <= set_data[1];
                end
                default: ;
            endcase
        end
    end

    assign i_tready  = o_tready | ~o_tvalid;
    assign accept    = i_tvalid & i_tready;
    assign qual      = i_tdata[31:16] >= thresh;
    assign plen      = CW'(1) << len_log2;
    assign phase_ext = {{(AW-16){i_tdata[15]}}, i_tdata[15:0]};
    assign acc_sum   = acc + phase_ext;
    assign cnt_inc   = cnt + CW'(1);
    assign hcnt_inc  = {1'b0, hcnt} + 17'd1;
    assign locked    = (state == S_LOCKED);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        hcnt_n   = hcnt;
        fire     = 1'b0;
        fire_acc = acc_sum;
        case (state)
            S_IDLE: if (enable) state_n = S_SEARCH;
            S_SEARCH: begin
                if (qual) begin
                    cnt_n    = CW'(1);
                    acc_n    = phase_ext;
                    fire_acc = phase_ext;
                    if (plen == CW'(1)) fire = 1'b1;
                    else                state_n = S_PLATEAU;
                end
            end
            S_PLATEAU: begin
                if (qual) begin
                    cnt_n = cnt_inc;
                    acc_n = acc_sum;
                    if (cnt_inc >= plen) fire = 1'b1;
                end else begin
                    state_n = S_SEARCH;
                    cnt_n   = '0;
                    acc_n   = '0;
                end
            end
            S_HOLDOFF: begin
                if (hcnt_inc >= {1'b0, holdoff}) begin
                    state_n = S_SEARCH;
                    hcnt_n  = '0;
                end else begin
                    hcnt_n = hcnt_inc[15:0];
                end
            end
            S_LOCKED: ;
            default: state_n = S_IDLE;
        endcase

        if (fire) begin
            cnt_n  = '0;
            acc_n  = '0;
            hcnt_n = '0;
            if (one_shot)             state_n = S_LOCKED;
            else if (holdoff == 16'd0) state_n = S_SEARCH;
            else                      state_n = S_HOLDOFF;
        end

`ifdef SC_SYNC_TLAST_RESYNC_EN
        // A completing trigger is still emitted; only the follow-on state is overridden.
        if (i_tlast && (state == S_PLATEAU || state == S_HOLDOFF)) begin
            state_n = S_SEARCH;
            cnt_n   = '0;
            acc_n   = '0;
            hcnt_n  = '0;
        end
`endif

        if (!enable) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            acc_n   = '0;
            hcnt_n  = '0;
            fire    = 1'b0;
        end

        held_shift = fire_acc >>> len_log2;
        held_n     = fire ? held_shift[15:0] : held;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            hcnt       <= '0;
            held       <= '0;
            trig_count <= '0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
            o_tvalid   <= 1'b0;
        end else if (clear) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            hcnt       <= '0;
            held       <= '0;
            trig_count <= '0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
            o_tvalid   <= 1'b0;
        end else if (accept) begin
            state      <= state_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            hcnt       <= hcnt_n;
            held       <= held_n;
            trig_count <= trig_count + {15'd0, fire};
            o_tdata    <= {15'd0, fire, held_n};
            o_tlast    <= i_tlast;
            o_tvalid   <= 1'b1;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sc_sync_ctrl.sv
// Directed self-checking bench for sc_sync_ctrl; expectations are hand-computed per scenario.
module tb_sc_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data, i_tdata, o_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic        o_tlast, o_tvalid, o_tready, locked;
    logic [15:0] trig_count;
    logic        rand_ready = 1'b0;
    logic        rnd_ready = 1'b1;
    logic        force_ready = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    assign o_tready = rand_ready ? rnd_ready : force_ready;

    sc_sync_ctrl #(.BASE(0), .MAX_LEN_LOG2(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .locked(locked), .trig_count(trig_count)
    );

    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: records transferred beats and checks that stalled beats hold still.
    always @(negedge clk) begin
        if (prev_stall) begin
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last) begin
                errors++;
                $display("FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                         o_tvalid, o_tdata, o_tlast, prev_data, prev_last);
            end
        end
        prev_stall = o_tvalid && !o_tready && !reset && !clear;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
        if (o_tvalid && o_tready && !reset) begin
            q_data.push_back(o_tdata);
            q_last.push_back(o_tlast);
        end
    end

    function automatic logic [31:0] w(input int t, input int h);
        return {15'd0, t[0], h[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        set_addr = a[7:0];
        set_data = d;
        set_stb  = 1'b1;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic cfg(input int th, input int len, input int ho, input int ctrl);
        wr(0, th);
        wr(1, len);
        wr(2, ho);
        wr(3, ctrl);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic beat(input int m, input int p, input int l);
        i_tdata  = {m[15:0], p[15:0]};
        i_tlast  = l[0];
        i_tvalid = 1'b1;
        tick();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic flush();
        tick();
        tick();
    endtask

    // Clear, then spend one non-qualifying beat leaving IDLE so plateau beats count from 1.
    task automatic start();
        pulse_clear();
        beat(0, 0, 0);
        flush();
        q_data.delete();
        q_last.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; force_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (o_tvalid !== 1'b0 || o_tdata !== 32'd0 || o_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h l=%b expected 0/0/0", o_tvalid, o_tdata, o_tlast);
        end
        checks++;
        if (locked !== 1'b0 || trig_count !== 16'd0 || i_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got lock=%b cnt=%h rdy=%b expected 0/0/1", locked, trig_count, i_tready);
        end
        reset = 1'b0;
        force_ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp[$];
        cfg(1000, 2, 0, 1);
        start();
        for (int i = 0; i < 8; i++) beat(2000, 100, (i == 7) ? 1 : 0);
        flush();
        exp = '{w(0,0), w(0,0), w(0,0), w(1,100), w(0,100), w(0,100), w(0,100), w(1,100)};
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i] || q_last[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL basic_beat%0d: got %h/%b expected %h/%b", i, q_data[i], q_last[i], exp[i], i == 7);
                end
            end
        end
        checks++;
        if (trig_count !== 16'd2) begin
            errors++;
            $display("FAIL basic_trig_count: got %0d expected 2", trig_count);
        end
    endtask

    task automatic test_phase_avg();
        logic [31:0] exp[$];
        int ph[12] = '{100, 200, 300, 400, -40, -40, -40, -40, -3, 0, 0, 0};
        cfg(1000, 2, 0, 1);
        start();
        for (int i = 0; i < 12; i++) beat(2000, ph[i], 0);
        flush();
        exp = '{w(0,0), w(0,0), w(0,0), w(1,250), w(0,250), w(0,250), w(0,250), w(1,'hFFD8),
                w(0,'hFFD8), w(0,'hFFD8), w(0,'hFFD8), w(1,'hFFFF)};
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL phase_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL phase_beat%0d: got %h expected %h", i, q_data[i], exp[i]);
                end
            end
        end
        checks++;
        if (trig_count !== 16'd3) begin
            errors++;
            $display("FAIL phase_trig_count: got %0d expected 3", trig_count);
        end
    endtask

    task automatic test_broken();
        logic [31:0] exp[$];
        int m[7] = '{2000, 1000, 999, 1000, 2000, 2000, 1000};
        cfg(1000, 2, 0, 1);
        start();
        for (int i = 0; i < 7; i++) beat(m[i], 8, 0);
        flush();
        exp = '{w(0,0), w(0,0), w(0,0), w(0,0), w(0,0), w(0,0), w(1,8)};
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL broken_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL broken_beat%0d: got %h expected %h", i, q_data[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_holdoff();
        cfg(1000, 2, 5, 1);
        start();
        for (int i = 0; i < 13; i++) beat(2000, 4, 0);
        flush();
        checks++;
        if (q_data.size() != 13) begin
            errors++;
            $display("FAIL holdoff_count: got %0d beats expected 13", q_data.size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                checks++;
                if (q_data[i] !== w((i == 3 || i == 12) ? 1 : 0, (i >= 3) ? 4 : 0)) begin
                    errors++;
                    $display("FAIL holdoff_beat%0d: got %h expected %h", i, q_data[i],
                             w((i == 3 || i == 12) ? 1 : 0, (i >= 3) ? 4 : 0));
                end
            end
        end
    endtask

    task automatic test_one_shot();
        cfg(1000, 2, 0, 3);
        start();
        for (int i = 0; i < 8; i++) beat(2000, 4, 0);
        flush();
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL oneshot_count: got %0d beats expected 8", q_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_data[i] !== w((i == 3) ? 1 : 0, (i >= 3) ? 4 : 0)) begin
                    errors++;
                    $display("FAIL oneshot_beat%0d: got %h expected %h", i, q_data[i],
                             w((i == 3) ? 1 : 0, (i >= 3) ? 4 : 0));
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || trig_count !== 16'd1) begin
            errors++;
            $display("FAIL oneshot_locked: got lock=%b cnt=%0d expected 1/1", locked, trig_count);
        end
        pulse_clear();
        checks++;
        if (locked !== 1'b0 || trig_count !== 16'd0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear: got lock=%b cnt=%0d v=%b expected 0/0/0", locked, trig_count, o_tvalid);
        end
        start();
        for (int i = 0; i < 4; i++) beat(2000, 4, 0);
        wr(3, 0);
        beat(0, 0, 0);
        flush();
        checks++;
        if (q_data.size() != 5 || q_data[3] !== w(1, 4) || q_data[4] !== w(0, 4) || locked !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_disable: got n=%0d lock=%b expected n=5 trig %h then %h lock=0",
                     q_data.size(), locked, w(1, 4), w(0, 4));
        end
    endtask

    task automatic test_len_bounds();
        logic [31:0] exp[$];
        cfg(1000, 0, 0, 1);
        start();
        beat(2000, 7, 0);
        beat(500, 9, 0);
        beat(2000, -5, 0);
        beat(2000, 3, 0);
        flush();
        exp = '{w(1,7), w(0,7), w(1,'hFFFB), w(1,3)};
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL len1_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL len1_beat%0d: got %h expected %h", i, q_data[i], exp[i]);
                end
            end
        end
        // len_log2=15 must clamp to 8, i.e. a 256-beat plateau.
        cfg(1000, 15, 0, 1);
        start();
        for (int i = 0; i < 256; i++) beat(2000, 2, 0);
        flush();
        checks++;
        if (q_data.size() != 256) begin
            errors++;
            $display("FAIL clamp_count: got %0d beats expected 256", q_data.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (q_data[i] !== ((i == 255) ? w(1, 2) : w(0, 0))) begin
                    errors++;
                    $display("FAIL clamp_beat%0d: got %h expected %h", i, q_data[i],
                             (i == 255) ? w(1, 2) : w(0, 0));
                end
            end
        end
    endtask

    task automatic test_simul_write();
        cfg(1000, 2, 0, 1);
        start();
        for (int i = 0; i < 3; i++) beat(2000, 40, 0);
        i_tdata  = {16'd2000, 16'd40};
        i_tvalid = 1'b1;
        set_addr = 8'd1;
        set_data = 32'd0;
        set_stb  = 1'b1;
        tick();
        i_tvalid = 1'b0;
        set_stb  = 1'b0;
        beat(2000, 12, 0);
        flush();
        checks++;
        if (q_data.size() != 5 || q_data[3] !== w(1, 40) || q_data[4] !== w(1, 12)) begin
            errors++;
            $display("FAIL simul_write: got n=%0d %h %h expected n=5 %h %h", q_data.size(),
                     (q_data.size() > 3) ? q_data[3] : 32'd0, (q_data.size() > 4) ? q_data[4] : 32'd0,
                     w(1, 40), w(1, 12));
        end
    endtask

    task automatic test_tlast();
        logic [31:0] exp[$];
        cfg(1000, 2, 0, 1);
        start();
        for (int i = 0; i < 6; i++) beat(2000, 20, (i == 1) ? 1 : 0);
        flush();
`ifdef SC_SYNC_TLAST_RESYNC_EN
        exp = '{w(0,0), w(0,0), w(0,0), w(0,0), w(0,0), w(1,20)};
`else
        exp = '{w(0,0), w(0,0), w(0,0), w(1,20), w(0,20), w(0,20)};
`endif
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL tlast_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i] || q_last[i] !== (i == 1)) begin
                    errors++;
                    $display("FAIL tlast_beat%0d: got %h/%b expected %h/%b", i, q_data[i], q_last[i], exp[i], i == 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp[$];
        int  idle;
        logic r, got;
        cfg(1000, 2, 0, 1);
        start();
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle = $urandom_range(0, 2);
            repeat (idle) tick();
            i_tdata  = {16'd2000, 16'd100};
            i_tlast  = (i == 7);
            i_tvalid = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                r = i_tready;
                @(posedge clk);
                #1;
                got = r;
            end
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL stall_accept%0d: got no handshake expected accept within 100 cycles", i);
            end
        end
        for (int k = 0; k < 200 && q_data.size() < 8; k++) tick();
        rand_ready = 1'b0;
        tick();
        exp = '{w(0,0), w(0,0), w(0,0), w(1,100), w(0,100), w(0,100), w(0,100), w(1,100)};
        checks++;
        if (q_data.size() != exp.size()) begin
            errors++;
            $display("FAIL stall_count: got %0d beats expected %0d", q_data.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                checks++;
                if (q_data[i] !== exp[i] || q_last[i] !== (i == 7)) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", i, q_data[i], q_last[i], exp[i], i == 7);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg(1000, 2, 0, 1);
        start();
        beat(2000, 50, 0);
        beat(2000, 50, 0);
        force_ready = 1'b0;
        checks++;
        if (o_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_pending: got v=%b expected 1", o_tvalid);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (o_tvalid !== 1'b0 || o_tdata !== 32'd0 || trig_count !== 16'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_async: got v=%b d=%h cnt=%0d lock=%b expected all 0",
                     o_tvalid, o_tdata, trig_count, locked);
        end
        #2 reset = 1'b0;
        force_ready = 1'b1;
        tick();
        // Default thresh 0xFFFF and len_log2 4: only metric 0xFFFF qualifies, 16-beat plateau.
        wr(3, 1);
        start();
        beat('hFFFE, 9, 0);
        for (int i = 0; i < 16; i++) beat('hFFFF, 9, 0);
        flush();
        checks++;
        if (q_data.size() != 17) begin
            errors++;
            $display("FAIL defaults_count: got %0d beats expected 17", q_data.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (q_data[i] !== ((i == 16) ? w(1, 9) : w(0, 0))) begin
                    errors++;
                    $display("FAIL defaults_beat%0d: got %h expected %h", i, q_data[i],
                             (i == 16) ? w(1, 9) : w(0, 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase_avg();
        test_broken();
        test_holdoff();
        test_one_shot();
        test_len_bounds();
        test_simul_write();
        test_tlast();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
